// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// The scoreboard dest field is sized for the widest supported register address.
package pipe_hazard_unit_pkg;

    localparam int DEST_W_MAX = 8;

    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [DEST_W_MAX-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_hazard_operand_match.sv
// Priority match of one source operand against the in-flight scoreboard:
// youngest producer wins, then readiness decides between forward and hazard.
module hazard_operand_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_RDY    = 2,
    parameter int LOAD_RDY   = 3,
    parameter int RF_BYPASS  = 1,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t [DEPTH:1]      sb,
    input  logic [REG_ADDR_W-1:0]    src,
    input  logic                     use_src,
    output logic                     hazard,
    output logic [SEL_W-1:0]         fwd
);

    logic [DEST_W_MAX-1:0] src_ext;
    logic                  found;

    assign src_ext = DEST_W_MAX'(src);

    always_comb begin
        hazard = 1'b0;
        fwd    = SEL_W'(FWD_RF);
        found  = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && use_src && (src_ext != '0) && sb[k].valid &&
                sb[k].regwrite && (sb[k].dest == src_ext)) begin
                found = 1'b1;
                if (k >= (sb[k].memread ? LOAD_RDY : ALU_RDY)) begin
                    // write-before-read register file already supplies the WB value
                    if (!((k == DEPTH) && (RF_BYPASS != 0)))
                        fwd = SEL_W'(k);
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: scoreboard shift-chain of in-flight
// destinations driving stall, flush, bubble and forward selects.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DEPTH      = STG_WB,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_RDY    = 2,
    parameter int LOAD_RDY   = 3,
    parameter int RF_BYPASS  = 1,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rs_i,
    input  logic                  id_use_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dest_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  redirect_i,
    output logic                  stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic [SEL_W-1:0]      fwd_a_o,
    output logic [SEL_W-1:0]      fwd_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    sb_entry_t [DEPTH:1] sb_q;
    sb_entry_t           sb_in;
    logic                hazard_a;
    logic                hazard_b;
    logic                issue;

    hazard_operand_match #(
        .DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .ALU_RDY(ALU_RDY),
        .LOAD_RDY(LOAD_RDY), .RF_BYPASS(RF_BYPASS), .SEL_W(SEL_W)
    ) u_match_rs (
        .sb      (sb_q),
        .src     (id_rs_i),
        .use_src (id_use_rs_i),
        .hazard  (hazard_a),
        .fwd     (fwd_a_o)
    );

    hazard_operand_match #(
        .DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .ALU_RDY(ALU_RDY),
        .LOAD_RDY(LOAD_RDY), .RF_BYPASS(RF_BYPASS), .SEL_W(SEL_W)
    ) u_match_rt (
        .sb      (sb_q),
        .src     (id_rt_i),
        .use_src (id_use_rt_i),
        .hazard  (hazard_b),
        .fwd     (fwd_b_o)
    );

    // redirect outranks a pending hazard: the ID instruction is being squashed anyway
    assign stall_o       = id_valid_i && (hazard_a || hazard_b) && !redirect_i;
    assign idex_bubble_o = stall_o || redirect_i;
    assign ifid_flush_o  = redirect_i;
    assign issue         = id_valid_i && !stall_o && !redirect_i;

    always_comb begin
        sb_in = '0;
        if (issue) begin
            sb_in.valid    = 1'b1;
            sb_in.dest     = DEST_W_MAX'(id_dest_i);
            sb_in.regwrite = id_regwrite_i;
            sb_in.memread  = id_memread_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q <= '0;
        end else begin
            sb_q[STG_EX] <= sb_in;
            for (int k = STG_MEM; k <= DEPTH; k++)
                sb_q[k] <= sb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (redirect_i)
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit at default parameters: a vector table
// against a fixed scoreboard, plus multi-cycle stall/redirect/reset sequences.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid_i;
    logic [4:0]  id_rs_i, id_rt_i, id_dest_i;
    logic        id_use_rs_i, id_use_rt_i;
    logic        id_regwrite_i, id_memread_i;
    logic        redirect_i;
    logic        stall_o, ifid_flush_o, idex_bubble_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_use_rs_i   (id_use_rs_i),
        .id_use_rt_i   (id_use_rt_i),
        .id_dest_i     (id_dest_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .redirect_i    (redirect_i),
        .stall_o       (stall_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       redirect;
        logic       exp_stall;
        logic       exp_flush;
        logic       exp_bubble;
        logic [1:0] exp_fwd_a;
        logic [1:0] exp_fwd_b;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input int rs, input int rt,
                          input logic urs, input logic urt, input int dest,
                          input logic rw, input logic mr, input logic redir);
        id_valid_i    = v;
        id_rs_i       = 5'(rs);
        id_rt_i       = 5'(rt);
        id_use_rs_i   = urs;
        id_use_rt_i   = urt;
        id_dest_i     = 5'(dest);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        redirect_i    = redir;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // sb after setup: 1 = lw $7, 2 = add $6, 3 = add $5
        //            valid rs  rt  urs  urt  redir stall flush bub fa fb
        vecs[0] = '{1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[1] = '{1'b1, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2};
        vecs[2] = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[3] = '{1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[4] = '{1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[5] = '{1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        vecs[6] = '{1'b1, 5'd6, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[7] = '{1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};

        idle();
        reset = 1'b0;
        #12;
        reset = 1'b1;
        #1;
        check("rst_stall", int'(stall_o), 0);
        check("rst_flush", int'(ifid_flush_o), 0);
        check("rst_bubble", int'(idex_bubble_o), 0);
        check("rst_fwd_a", int'(fwd_a_o), 0);
        check("rst_fwd_b", int'(fwd_b_o), 0);
        check("rst_stall_cnt", int'(stall_cnt_o), 0);
        check("rst_flush_cnt", int'(flush_cnt_o), 0);

        tick();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i].valid, int'(vecs[i].rs), int'(vecs[i].rt), vecs[i].use_rs,
                   vecs[i].use_rt, 0, 1'b0, 1'b0, vecs[i].redirect);
            #1;
            check($sformatf("vec%0d_stall", i), int'(stall_o), int'(vecs[i].exp_stall));
            check($sformatf("vec%0d_flush", i), int'(ifid_flush_o), int'(vecs[i].exp_flush));
            check($sformatf("vec%0d_bubble", i), int'(idex_bubble_o), int'(vecs[i].exp_bubble));
            check($sformatf("vec%0d_fwd_a", i), int'(fwd_a_o), int'(vecs[i].exp_fwd_a));
            check($sformatf("vec%0d_fwd_b", i), int'(fwd_b_o), int'(vecs[i].exp_fwd_b));
        end

        // load-use: lw $8 ; add $9,$8,$10
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_lw_nostall", int'(stall_o), 0);
        tick();
        set_id(1'b1, 8, 10, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall1", int'(stall_o), 1);
        check("lu_bubble1", int'(idex_bubble_o), 1);
        tick();
        check("lu_stall2", int'(stall_o), 1);
        check("lu_bubble2", int'(idex_bubble_o), 1);
        tick();
        check("lu_release", int'(stall_o), 0);
        check("lu_fwd_a", int'(fwd_a_o), 0);
        check("lu_stall_cnt", int'(stall_cnt_o), 2);

        // ALU-use: add $8 ; sub $11,$8,$8
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 8, 8, 1'b1, 1'b1, 11, 1'b1, 1'b0, 1'b0);
        #1;
        check("au_stall", int'(stall_o), 1);
        tick();
        check("au_release", int'(stall_o), 0);
        check("au_fwd_a", int'(fwd_a_o), 2);
        check("au_fwd_b", int'(fwd_b_o), 2);
        check("au_stall_cnt", int'(stall_cnt_o), 1);

        // youngest producer wins: add $8 ; add $8 ; or $12,$8,$0
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        set_id(1'b1, 8, 0, 1'b1, 1'b1, 12, 1'b1, 1'b0, 1'b0);
        #1;
        check("yw_stall", int'(stall_o), 1);
        tick();
        check("yw_release", int'(stall_o), 0);
        check("yw_fwd_a", int'(fwd_a_o), 2);
        check("yw_fwd_b", int'(fwd_b_o), 0);

        // $0 is never a hazard
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        #1;
        check("r0_stall", int'(stall_o), 0);
        check("r0_fwd_a", int'(fwd_a_o), 0);
        check("r0_fwd_b", int'(fwd_b_o), 0);

        // redirect beats load-use; squashed instruction never enters the scoreboard
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 8, 0, 1'b1, 1'b0, 12, 1'b1, 1'b0, 1'b1);
        #1;
        check("rd_stall", int'(stall_o), 0);
        check("rd_flush", int'(ifid_flush_o), 1);
        check("rd_bubble", int'(idex_bubble_o), 1);
        check("rd_flush_cnt0", int'(flush_cnt_o), 0);
        tick();
        check("rd_flush_cnt1", int'(flush_cnt_o), 1);
        set_id(1'b1, 12, 0, 1'b1, 1'b0, 13, 1'b1, 1'b0, 1'b0);
        #1;
        check("rd_e1_invalid", int'(stall_o), 0);
        check("rd_e1_fwd", int'(fwd_a_o), 0);
        check("rd_stall_cnt", int'(stall_cnt_o), 0);

        // asynchronous reset in the middle of a stall
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 8, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b0);
        #1;
        check("ar_stall", int'(stall_o), 1);
        tick();
        check("ar_stall_cnt", int'(stall_cnt_o), 1);
        reset = 1'b0;
        #1;
        check("ar_stall_drop", int'(stall_o), 0);
        check("ar_bubble_drop", int'(idex_bubble_o), 0);
        check("ar_cnt_clear", int'(stall_cnt_o), 0);
        #1;
        reset = 1'b1;
        #1;
        check("ar_post_stall", int'(stall_o), 0);
        check("ar_post_fwd", int'(fwd_a_o), 0);
        tick();
        check("ar_post_tick_fwd", int'(fwd_a_o), 0);
        check("ar_post_tick_stall", int'(stall_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS datapath.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Keeps its own scoreboard shift-chain of in-flight destination registers and drives, from it: load-use stall, IF/ID freeze, bubble insertion, flush-on-redirect and per-operand forward selects.
- Generalises to any pipeline depth and load latency; also counts stall and flush cycles.

Parameters:
- DEPTH, 3: number of tracked post-decode stages (1=EX, 2=MEM, ..., DEPTH=WB).
- REG_ADDR_W, 5: register address width.
- ALU_RDY, 2: lowest stage index whose ALU result may be forwarded.
- LOAD_RDY, 3: lowest stage index whose load data may be forwarded; LOAD_RDY ≥ ALU_RDY, ≤ DEPTH.
- RF_BYPASS, 1: 1 = register file is write-before-read, so a match in stage DEPTH needs no forward.
- SEL_W, 2: width of forward select, ≥ clog2(DEPTH+1).
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID holds a live instruction
- id_rs_i  in  REG_ADDR_W  source A register
- id_rt_i  in  REG_ADDR_W  source B register
- id_use_rs_i  in  1  instruction reads rs
- id_use_rt_i  in  1  instruction reads rt
- id_dest_i  in  REG_ADDR_W  destination (after RegDst/jal mux)
- id_regwrite_i  in  1  instruction writes a register
- id_memread_i  in  1  instruction is a load
- redirect_i  in  1  branch taken / jump / jr resolved this cycle
- stall_o  out  1  freeze PC and IF/ID; bubble into ID/EX
- ifid_flush_o  out  1  clear IF/ID
- idex_bubble_o  out  1  ID/EX loads a NOP
- fwd_a_o  out  SEL_W  source for operand A: 0 = register file, k = stage k
- fwd_b_o  out  SEL_W  same, for operand B
- stall_cnt_o  out  CNT_W  cycles with stall_o=1
- flush_cnt_o  out  CNT_W  cycles with redirect_i=1

Behaviour:
- Scoreboard: DEPTH entries, each holding {valid, dest, regwrite, memread}.
- Every clock, entry k moves to k+1 and entry DEPTH retires. Downstream stages never stall.
- Entry 1 loads the ID fields when id_valid_i && !stall_o && !redirect_i; otherwise entry 1 becomes invalid (bubble).
- Match(k, src): valid[k] && regwrite[k] && dest[k]==src && src!=0 && use flag set.
- For each operand, take the lowest k that matches (youngest producer wins):
  - Ready iff k ≥ (memread[k] ? LOAD_RDY : ALU_RDY).
  - Ready: fwd = k, except fwd = 0 when k==DEPTH and RF_BYPASS=1.
  - Not ready: hazard. fwd is don't-care; drive 0.
  - No match: fwd = 0.
- stall_o = id_valid_i && (hazard_a || hazard_b) && !redirect_i.
- idex_bubble_o = stall_o || redirect_i.
- ifid_flush_o = redirect_i.
- Redirect and hazard in the same cycle: redirect wins, no stall.
- Stall, fwd, bubble and flush outputs are combinational from scoreboard state and ID inputs.
- Back-to-back load-use stalls for LOAD_RDY-1 cycles: 2 cycles at defaults with DEPTH=3.
- Counters: registered, increment by 1, wrap from max to 0.
- Reset (reset=0, asynchronous): all valid=0, counters=0.
  - stall_o, ifid_flush_o, idex_bubble_o, fwd_a_o and fwd_b_o are then 0, since they are combinational from the cleared scoreboard and gated by id_valid_i.
  - Reset asserted mid-stall clears the stall immediately.
- Register $0 is never a hazard and never forwarded.

Decomposition:
- Shared package holds:
  - scoreboard entry struct {valid, dest, regwrite, memread};
  - stage index constants STG_EX=1, STG_MEM=2, STG_WB=3;
  - FWD_RF=0.
- One sub-module, hazard_operand_match: one operand's priority match, readiness and select logic. Instantiated twice (rs, rt).

Test Plan:
- lw $8 then add $9,$8,$10 back-to-back (defaults) → stall_o=1 for 2 cycles, idex_bubble_o=1 each, then fwd_a_o=0 (RF bypass), stall_cnt_o=2.
- add $8 then sub $11,$8,$8 → no stall; fwd_a_o=fwd_b_o=1? No: stage 1 < ALU_RDY, so 1 stall cycle, then fwd_a_o=fwd_b_o=2.
- add $8; add $8; or $12,$8,$0, third instruction in ID once both producers are in stages 2/3 → fwd_a_o=2 (youngest wins), fwd_b_o=0.
- lw $0 followed by a reader of $0 → stall_o=0, fwd=0.
- redirect_i=1 while a load-use hazard is present → stall_o=0, ifid_flush_o=1, idex_bubble_o=1, flush_cnt_o increments, entry 1 invalid next cycle.
- reset pulsed low during a stall → stall_o drops asynchronously, counters read 0, no forwarding after release until a new producer issues.
